// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/flush controller.
// Merges per-stage stall requests into a hold vector, turns precise mem-stage
// exceptions and branch mispredicts into a single-cycle flush with a redirect PC,
// and counts exception flushes. Flush/redirect/stall outputs are combinational
// so the commit stage can act on them in the same cycle they are raised.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        exception_i,
    input  logic        exc_is_eret_i,
    input  logic [31:0] exc_epc_i,
    input  logic        mispredict_i,
    input  logic [31:0] mispredict_target_i,
    output logic [3:0]  stall_o,
    output logic        flush_o,
    output logic        flush_cause_o,
    output logic [31:0] new_pc_o,
    output logic [15:0] exc_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXC_WAIT = 2'd1,
        RECOVER  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pend_pc_r;
    logic [31:0] pend_pc_nxt_s;
    logic [15:0] exc_cnt_r;
    logic [3:0]  stall_req_s;
    logic [31:0] exc_target_s;
    logic        flush_s;
    logic        flush_cause_s;
    logic [31:0] new_pc_s;
    logic [3:0]  stall_s;

    // Exception redirect target: ERET returns to EPC, everything else to the handler.
    always_comb begin
        if (exc_is_eret_i) begin
            exc_target_s = exc_epc_i;
        end else begin
            exc_target_s = EXC_VECTOR;
        end
    end

    // Stall-request priority encoder; deeper stages freeze everything upstream.
    always_comb begin
        if (stallreq_mem_i || stallreq_ex_i) begin
            stall_req_s = 4'b0111;
        end else if (stallreq_id_i) begin
            stall_req_s = 4'b0011;
        end else if (stallreq_if_i) begin
            stall_req_s = 4'b0001;
        end else begin
            stall_req_s = 4'b0000;
        end
    end

    // Next-state and zero-latency flush/redirect/stall decision.
    always_comb begin
        state_nxt_s   = state_r;
        pend_pc_nxt_s = pend_pc_r;
        flush_s       = 1'b0;
        flush_cause_s = 1'b0;
        new_pc_s      = 32'h0000_0000;
        stall_s       = stall_req_s;
        case (state_r)
            IDLE, RECOVER: begin
                if (exception_i) begin
                    if (!stallreq_mem_i) begin
                        flush_s       = 1'b1;
                        flush_cause_s = 1'b1;
                        new_pc_s      = exc_target_s;
                        stall_s       = 4'b0000;
                        state_nxt_s   = RECOVER;
                    end else begin
                        // Mem still busy: hold the front end and remember where to go.
                        stall_s       = 4'b0111;
                        pend_pc_nxt_s = exc_target_s;
                        state_nxt_s   = EXC_WAIT;
                    end
                end else if ((state_r == IDLE) && mispredict_i &&
                             !stallreq_ex_i && !stallreq_mem_i) begin
                    flush_s       = 1'b1;
                    flush_cause_s = 1'b0;
                    new_pc_s      = mispredict_target_i;
                    stall_s       = 4'b0000;
                    state_nxt_s   = RECOVER;
                end else begin
                    // Mispredict in RECOVER is the stale copy of the one just flushed.
                    state_nxt_s = IDLE;
                end
            end
            EXC_WAIT: begin
                if (stallreq_mem_i) begin
                    stall_s = 4'b0111;
                end else begin
                    flush_s       = 1'b1;
                    flush_cause_s = 1'b1;
                    new_pc_s      = pend_pc_r;
                    stall_s       = 4'b0000;
                    state_nxt_s   = RECOVER;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and pending-target registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            pend_pc_r <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            pend_pc_r <= pend_pc_nxt_s;
        end
    end

    // Saturating count of exception flushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt_r <= 16'h0000;
        end else if (flush_s && flush_cause_s && (exc_cnt_r != 16'hFFFF)) begin
            exc_cnt_r <= exc_cnt_r + 16'h0001;
        end else begin
            exc_cnt_r <= exc_cnt_r;
        end
    end

    assign stall_o       = stall_s;
    assign flush_o       = flush_s;
    assign flush_cause_o = flush_cause_s;
    assign new_pc_o      = new_pc_s;
    assign exc_cnt_o     = exc_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic        exception_i;
    logic        exc_is_eret_i;
    logic [31:0] exc_epc_i;
    logic        mispredict_i;
    logic [31:0] mispredict_target_i;
    logic [3:0]  stall_o;
    logic        flush_o;
    logic        flush_cause_o;
    logic [31:0] new_pc_o;
    logic [15:0] exc_cnt_o;

    int vectors;
    int miscompares;

    pipe_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .stallreq_if_i       (stallreq_if_i),
        .stallreq_id_i       (stallreq_id_i),
        .stallreq_ex_i       (stallreq_ex_i),
        .stallreq_mem_i      (stallreq_mem_i),
        .exception_i         (exception_i),
        .exc_is_eret_i       (exc_is_eret_i),
        .exc_epc_i           (exc_epc_i),
        .mispredict_i        (mispredict_i),
        .mispredict_target_i (mispredict_target_i),
        .stall_o             (stall_o),
        .flush_o             (flush_o),
        .flush_cause_o       (flush_cause_o),
        .new_pc_o            (new_pc_o),
        .exc_cnt_o           (exc_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if_i       = 1'b0;
        stallreq_id_i       = 1'b0;
        stallreq_ex_i       = 1'b0;
        stallreq_mem_i      = 1'b0;
        exception_i         = 1'b0;
        exc_is_eret_i       = 1'b0;
        exc_epc_i           = 32'h0000_0000;
        mispredict_i        = 1'b0;
        mispredict_target_i = 32'h0000_0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (exc_cnt_o !== 16'h0000 || flush_o !== 1'b0 || new_pc_o !== 32'h0 || stall_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset: cnt=%h flush=%b pc=%h stall=%b, want cnt=0000 flush=0 pc=0 stall=0000",
                     exc_cnt_o, flush_o, new_pc_o, stall_o);
        end
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_exc_vector();
        exception_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b1 || flush_cause_o !== 1'b1 || new_pc_o !== 32'hBFC00380 || stall_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL exc_vector: flush=%b cause=%b pc=%h stall=%b, want 1 1 bfc00380 0000",
                     flush_o, flush_cause_o, new_pc_o, stall_o);
        end
        cyc();
        // RECOVER: mispredict must be ignored, counter advanced once
        exception_i         = 1'b0;
        mispredict_i        = 1'b1;
        mispredict_target_i = 32'h8000_0100;
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b0 || exc_cnt_o !== 16'd1) begin
            miscompares++;
            $display("FAIL exc_recover: flush=%b cnt=%0d, want flush=0 cnt=1", flush_o, exc_cnt_o);
        end
        cyc();
        // back in IDLE: held mispredict now flushes
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b1 || flush_cause_o !== 1'b0 || new_pc_o !== 32'h8000_0100) begin
            miscompares++;
            $display("FAIL mispred_after_recover: flush=%b cause=%b pc=%h, want 1 0 80000100",
                     flush_o, flush_cause_o, new_pc_o);
        end
        cyc();
        clear_inputs();
        cyc();
        vectors++;
        if (exc_cnt_o !== 16'd1) begin
            miscompares++;
            $display("FAIL cnt_branch_no_inc: cnt=%0d want 1", exc_cnt_o);
        end
    endtask

    task automatic test_exc_wait();
        exception_i    = 1'b1;
        exc_is_eret_i  = 1'b1;
        exc_epc_i      = 32'h8000_1234;
        stallreq_mem_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mispredict_i        = 1'b1;
                mispredict_target_i = 32'h8000_0200;
            end
            @(negedge clk);
            vectors++;
            if (flush_o !== 1'b0 || stall_o !== 4'b0111) begin
                miscompares++;
                $display("FAIL exc_wait_stall[%0d]: flush=%b stall=%b, want 0 0111", i, flush_o, stall_o);
            end
            cyc();
        end
        stallreq_mem_i = 1'b0;
        exc_epc_i      = 32'hDEAD_BEEF;
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b1 || flush_cause_o !== 1'b1 || new_pc_o !== 32'h8000_1234 || stall_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL exc_wait_flush: flush=%b cause=%b pc=%h stall=%b, want 1 1 80001234 0000",
                     flush_o, flush_cause_o, new_pc_o, stall_o);
        end
        cyc();
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b0 || exc_cnt_o !== 16'd2) begin
            miscompares++;
            $display("FAIL exc_wait_after: flush=%b cnt=%0d, want 0 2", flush_o, exc_cnt_o);
        end
        cyc();
    endtask

    task automatic test_mispredict();
        mispredict_i        = 1'b1;
        mispredict_target_i = 32'h8000_0040;
        stallreq_ex_i       = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (flush_o !== 1'b0 || stall_o !== 4'b0111) begin
                miscompares++;
                $display("FAIL mispred_defer[%0d]: flush=%b stall=%b, want 0 0111", i, flush_o, stall_o);
            end
            cyc();
        end
        stallreq_ex_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b1 || flush_cause_o !== 1'b0 || new_pc_o !== 32'h8000_0040 || stall_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL mispred_flush: flush=%b cause=%b pc=%h stall=%b, want 1 0 80000040 0000",
                     flush_o, flush_cause_o, new_pc_o, stall_o);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b0 || new_pc_o !== 32'h0 || exc_cnt_o !== 16'd2) begin
            miscompares++;
            $display("FAIL mispred_ignored: flush=%b pc=%h cnt=%0d, want 0 0 2", flush_o, new_pc_o, exc_cnt_o);
        end
        cyc();
        clear_inputs();
        cyc();
    endtask

    task automatic test_simultaneous();
        exception_i         = 1'b1;
        mispredict_i        = 1'b1;
        mispredict_target_i = 32'h8000_0080;
        @(negedge clk);
        vectors++;
        if (flush_o !== 1'b1 || flush_cause_o !== 1'b1 || new_pc_o !== 32'hBFC00380) begin
            miscompares++;
            $display("FAIL simultaneous: flush=%b cause=%b pc=%h, want 1 1 bfc00380",
                     flush_o, flush_cause_o, new_pc_o);
        end
        cyc();
        clear_inputs();
        cyc();
        vectors++;
        if (exc_cnt_o !== 16'd3) begin
            miscompares++;
            $display("FAIL simultaneous_cnt: cnt=%0d want 3", exc_cnt_o);
        end
    endtask

    task automatic test_stall_prio();
        // {if, id, ex, mem} -> expected stall
        logic [3:0] req_v [6] = '{4'b1000, 4'b0100, 4'b1100, 4'b0110, 4'b0001, 4'b0000};
        logic [3:0] exp_v [6] = '{4'b0001, 4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            stallreq_if_i  = req_v[i][3];
            stallreq_id_i  = req_v[i][2];
            stallreq_ex_i  = req_v[i][1];
            stallreq_mem_i = req_v[i][0];
            @(negedge clk);
            vectors++;
            if (stall_o !== exp_v[i] || flush_o !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_prio[%0d]: stall=%b flush=%b, want %b 0", i, stall_o, flush_o, exp_v[i]);
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_reset_exc_wait();
        exception_i    = 1'b1;
        stallreq_mem_i = 1'b1;
        cyc();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (exc_cnt_o !== 16'h0000 || flush_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: cnt=%0d flush=%b, want 0 0", exc_cnt_o, flush_o);
        end
        clear_inputs();
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (flush_o !== 1'b0 || stall_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_discard[%0d]: flush=%b stall=%b, want 0 0000", i, flush_o, stall_o);
            end
            cyc();
        end
    endtask

    task automatic test_saturation();
        exception_i = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            cyc();
        end
        @(negedge clk);
        vectors++;
        if (exc_cnt_o !== 16'hFFFE || flush_o !== 1'b1 || flush_cause_o !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_pre: cnt=%h flush=%b cause=%b, want fffe 1 1", exc_cnt_o, flush_o, flush_cause_o);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            vectors++;
            if (exc_cnt_o !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL sat_hold[%0d]: cnt=%h want ffff", i, exc_cnt_o);
            end
        end
        cyc();
        clear_inputs();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_exc_vector();
        test_exc_wait();
        test_mispredict();
        test_simultaneous();
        test_stall_prio();
        test_reset_exc_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
